// File: rtl/sad_pkg.sv
// Shared defaults for the sum-of-absolute-differences unit (datapath, controller, top level).
package sad_pkg;

  localparam int SAD_N  = 256;
  localparam int SAD_DW = 8;
  localparam int SAD_IW = $clog2(SAD_N) + 1;
  localparam int SAD_SW = SAD_DW + $clog2(SAD_N);

  typedef logic [SAD_SW-1:0] sad_t;

endpackage

// File: rtl/sad_absdiff.sv
// Unsigned absolute difference |a - b|, computed as larger minus smaller.
module sad_absdiff #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] i_a,
  input  logic [DW-1:0] i_b,
  output logic [DW-1:0] o_diff
);

  // NOTE: every branch of a combinational block assigns the output, so no latch is inferred.
  always_comb begin
    o_diff = '0;
    if (i_a >= i_b) o_diff = i_a - i_b;
    else            o_diff = i_b - i_a;
  end

endmodule

// File: rtl/sad_datapath.sv
// SAD datapath: index counter and memory addressing, |A-B| accumulator,
// SAD result register with valid pulse, and a sticky protocol-error flag.
module sad_datapath
  import sad_pkg::*;
#(
  parameter int N  = SAD_N,
  parameter int DW = SAD_DW,
  parameter int IW = $clog2(N) + 1,
  parameter int SW = DW + $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_inc,
  input  logic          sum_clr,
  input  logic          sum_ld,
  input  logic          AB_rd,
  input  logic          sadreg_clr,
  input  logic          sadreg_ld,
  output logic          i_lt_256,
  output logic [IW-2:0] A_addr,
  output logic [IW-2:0] B_addr,
  output logic          A_rd,
  output logic          B_rd,
  input  logic [DW-1:0] A_data,
  input  logic [DW-1:0] B_data,
  output logic [SW-1:0] sad,
  output logic          sad_valid,
  output logic          err
);

  logic [IW-1:0] r_idx;
  logic [SW-1:0] r_sum;
  logic [SW-1:0] r_sad;
  logic          r_sad_valid;
  logic          r_err;

  logic          w_idx_lt_n;
  logic [DW-1:0] w_absdiff;
  logic          w_sum_add;
  logic          w_err_evt;

  sad_absdiff #(.DW(DW)) u_absdiff (
    .i_a    (A_data),
    .i_b    (B_data),
    .o_diff (w_absdiff)
  );

  // Derived from the registered index only: no path from the control inputs.
  assign w_idx_lt_n = (r_idx < IW'(N));

  // An add needs a live read and an in-range index; otherwise it is dropped and flagged.
  assign w_sum_add = sum_ld & AB_rd & w_idx_lt_n;
  assign w_err_evt = (i_inc  & ~i_clr   & ~w_idx_lt_n)
                   | (sum_ld & ~sum_clr & (~w_idx_lt_n | ~AB_rd));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
  // this is what lets sadreg_ld capture the old sum while sum_clr clears it in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and active-low, checked first so it dominates every control.
    if (!rst) begin
      r_idx       <= '0;
      r_sum       <= '0;
      r_sad       <= '0;
      r_sad_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (i_clr)                   r_idx <= '0;
      else if (i_inc && w_idx_lt_n) r_idx <= r_idx + IW'(1);

      if (sum_clr)        r_sum <= '0;
      else if (w_sum_add) r_sum <= r_sum + SW'(w_absdiff);

      if (sadreg_clr)     r_sad <= '0;
      else if (sadreg_ld) r_sad <= r_sum;

      r_sad_valid <= sadreg_ld & ~sadreg_clr;

      if (w_err_evt) r_err <= 1'b1;
    end
  end

  assign i_lt_256  = w_idx_lt_n;
  assign A_addr    = r_idx[IW-2:0];
  assign B_addr    = r_idx[IW-2:0];
  assign A_rd      = AB_rd;
  assign B_rd      = AB_rd;
  assign sad       = r_sad;
  assign sad_valid = r_sad_valid;
  assign err       = r_err;

endmodule

// File: tb/tb_sad_datapath.sv
// Directed bench for sad_datapath: table of full-block patterns plus hand-written corner sequences.
module tb_sad_datapath;
  import sad_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_clr, i_inc, sum_clr, sum_ld, AB_rd, sadreg_clr, sadreg_ld;
  logic       i_lt_256, A_rd, B_rd, sad_valid, err;
  logic [7:0] A_addr, B_addr, A_data, B_data;
  sad_t       sad;

  logic [7:0] mem_a [0:255];
  logic [7:0] mem_b [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  sad_datapath dut (
    .clk(clk), .rst(rst),
    .i_clr(i_clr), .i_inc(i_inc), .sum_clr(sum_clr), .sum_ld(sum_ld), .AB_rd(AB_rd),
    .sadreg_clr(sadreg_clr), .sadreg_ld(sadreg_ld),
    .i_lt_256(i_lt_256), .A_addr(A_addr), .B_addr(B_addr), .A_rd(A_rd), .B_rd(B_rd),
    .A_data(A_data), .B_data(B_data), .sad(sad), .sad_valid(sad_valid), .err(err)
  );

  always #5 clk = ~clk;

  // Asynchronous-read memories.
  always_comb begin
    A_data = mem_a[A_addr];
    B_data = mem_b[B_addr];
  end

  // kind: 0 = constant, 1 = k, 2 = 255-k
  typedef struct {
    int a_kind; int a_const;
    int b_kind; int b_const;
    int exp_sad;
  } blk_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctrl();
    i_clr = 0; i_inc = 0; sum_clr = 0; sum_ld = 0; AB_rd = 0; sadreg_clr = 0; sadreg_ld = 0;
  endtask

  function automatic logic [7:0] pat(input int kind, input int c, input int k);
    case (kind)
      1:       pat = 8'(k);
      2:       pat = 8'(255 - k);
      default: pat = 8'(c);
    endcase
  endfunction

  task automatic fill(input int ak, input int ac, input int bk, input int bc);
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = pat(ak, ac, k);
      mem_b[k] = pat(bk, bc, k);
    end
  endtask

  task automatic accumulate(input int n);
    AB_rd = 1; sum_ld = 1; i_inc = 1;
    repeat (n) tick();
    idle_ctrl();
  endtask

  task automatic clear_block();
    i_clr = 1; sum_clr = 1;
    tick();
    idle_ctrl();
  endtask

  blk_vec_t vecs [6];

  initial begin
    vecs[0] = '{1, 0,   0, 0,   32640};
    vecs[1] = '{0, 255, 0, 0,   65280};
    vecs[2] = '{0, 0,   0, 255, 65280};
    vecs[3] = '{0, 3,   0, 1,   512};
    vecs[4] = '{0, 0,   1, 0,   32640};
    vecs[5] = '{1, 0,   2, 0,   32768};

    // Reset with every control asserted.
    i_clr = 1; i_inc = 1; sum_clr = 1; sum_ld = 1; AB_rd = 1; sadreg_clr = 1; sadreg_ld = 1;
    fill(0, 0, 0, 0);
    rst = 0;
    tick(); tick();
    check("rst_sad", 32'(sad), 0);
    check("rst_sad_valid", 32'(sad_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_index", 32'(dut.r_idx), 0);
    check("rst_i_lt_256", 32'(i_lt_256), 1);
    check("rd_passthru", {30'd0, A_rd, B_rd}, 3);
    idle_ctrl();
    rst = 1;
    tick();

    // Back-to-back full blocks: the result load shares a cycle with the next block's clears.
    clear_block();
    for (int v = 0; v < 6; v++) begin
      fill(vecs[v].a_kind, vecs[v].a_const, vecs[v].b_kind, vecs[v].b_const);
      check($sformatf("v%0d_lt_before", v), 32'(i_lt_256), 1);
      accumulate(255);
      check($sformatf("v%0d_lt_at_255", v), 32'(i_lt_256), 1);
      accumulate(1);
      check($sformatf("v%0d_lt_after", v), 32'(i_lt_256), 0);
      check($sformatf("v%0d_index", v), 32'(dut.r_idx), 256);
      sadreg_ld = 1; i_clr = 1; sum_clr = 1;
      tick();
      idle_ctrl();
      check($sformatf("v%0d_sad", v), 32'(sad), 32'(vecs[v].exp_sad));
      check($sformatf("v%0d_valid_hi", v), 32'(sad_valid), 1);
      check($sformatf("v%0d_err", v), 32'(err), 0);
      tick();
      check($sformatf("v%0d_valid_lo", v), 32'(sad_valid), 0);
      check($sformatf("v%0d_sad_hold", v), 32'(sad), 32'(vecs[v].exp_sad));
    end

    // Reset in the middle of a block, then a fresh block.
    fill(1, 0, 0, 0);
    clear_block();
    accumulate(100);
    check("mid_index_pre", 32'(A_addr), 100);
    rst = 0;
    AB_rd = 1; sum_ld = 1; i_inc = 1;
    tick();
    idle_ctrl();
    rst = 1;
    check("mid_sum", 32'(dut.r_sum), 0);
    check("mid_index", 32'(dut.r_idx), 0);
    check("mid_lt", 32'(i_lt_256), 1);
    fill(0, 3, 0, 1);
    accumulate(256);
    sadreg_ld = 1;
    tick();
    idle_ctrl();
    check("mid_fresh_sad", 32'(sad), 512);

    // Overrun at index N: add suppressed, index held, error sticky.
    AB_rd = 1; sum_ld = 1; i_inc = 1;
    tick();
    idle_ctrl();
    check("ovr_err", 32'(err), 1);
    check("ovr_sum", 32'(dut.r_sum), 512);
    check("ovr_index", 32'(dut.r_idx), 256);
    check("ovr_lt", 32'(i_lt_256), 0);
    clear_block();
    repeat (3) tick();
    check("ovr_err_sticky", 32'(err), 1);
    rst = 0;
    tick();
    rst = 1;
    check("ovr_err_reset", 32'(err), 0);

    // sum_ld without AB_rd is suppressed and flagged.
    fill(0, 7, 0, 0);
    sum_ld = 1;
    tick();
    idle_ctrl();
    check("nord_sum", 32'(dut.r_sum), 0);
    check("nord_err", 32'(err), 1);
    rst = 0;
    tick();
    rst = 1;

    // i_clr beats i_inc.
    i_inc = 1;
    repeat (5) tick();
    idle_ctrl();
    check("prio_idx5", 32'(A_addr), 5);
    i_clr = 1; i_inc = 1;
    tick();
    idle_ctrl();
    check("prio_iclr", 32'(A_addr), 0);

    // sadreg_ld with sum_clr latches the old sum.
    fill(0, 250, 0, 0);
    accumulate(4);
    check("prio_sum1000", 32'(dut.r_sum), 1000);
    sadreg_ld = 1; sum_clr = 1;
    tick();
    idle_ctrl();
    check("prio_sad_old", 32'(sad), 1000);
    check("prio_sum_clr", 32'(dut.r_sum), 0);
    check("prio_valid", 32'(sad_valid), 1);

    // sadreg_clr beats sadreg_ld; no valid pulse.
    sadreg_clr = 1; sadreg_ld = 1;
    tick();
    idle_ctrl();
    check("prio_sadclr", 32'(sad), 0);
    check("prio_sadclr_valid", 32'(sad_valid), 0);
    check("prio_err_clean", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
